// File: rtl/tick_sample_arbiter.sv
// tick_sample_arbiter
// Gathers period samples from NUM_CH tick-timer channels into per-channel
// 1-deep latest-value buffers and grants them round-robin onto one output.
//
// Output handshake: a sample transfers on any rising clk edge where
// out_valid and out_ready are both high. Once out_valid rises, out_period,
// out_sign and out_ch are held stable until that transfer. out_valid may
// drop only after a transfer.
//
// Optional feature: define TICK_STALL_TIMEOUT_EN to enable the per-channel
// stall monitor. When a channel sees no tick for TIMEOUT_US microseconds,
// the monitor injects a single MAX_PERIOD sample for that channel.
module tick_sample_arbiter #(
  parameter int          NUM_CH     = 4,
  parameter int          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int          TIMEOUT_US = 50000,
  parameter logic [31:0] MAX_PERIOD = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  us_tick,
  input  logic [NUM_CH-1:0]     tick_valid,
  input  logic [32*NUM_CH-1:0]  tick_period,
  input  logic [NUM_CH-1:0]     tick_sign,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_period,
  output logic                  out_sign,
  output logic [CH_W-1:0]       out_ch,
  output logic [NUM_CH-1:0]     overrun,
  input  logic                  clear_overrun
);

  // Per-channel latest-value buffers
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [31:0]       pper_q [NUM_CH];
  logic [31:0]       pper_d [NUM_CH];
  logic [NUM_CH-1:0] psgn_q, psgn_d;

  // Output register and arbitration state
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_period_q, out_period_d;
  logic              out_sign_q, out_sign_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;

  // Arbitration results
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic              out_free;
  logic              take;

  // Stall monitor interface into the buffer logic
  logic [NUM_CH-1:0] stall_fire;
  logic [NUM_CH-1:0] stall_sign;

`ifdef TICK_STALL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_US + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_US);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] armed_q;
  logic [NUM_CH-1:0] last_sign_q;

  // Stall fires once the armed counter has saturated. A real tick in the
  // same cycle takes precedence over the stall.
  always_comb begin
    stall_fire = '0;
    stall_sign = last_sign_q;
    for (int i = 0; i < NUM_CH; i++) begin
      stall_fire[i] = armed_q[i] && (cnt_q[i] == CNT_MAX) && !tick_valid[i];
    end
  end

  // Per-channel microsecond counters, re-armed by each real tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      armed_q     <= '1;
      last_sign_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tick_valid[i]) begin
          cnt_q[i]       <= '0;
          armed_q[i]     <= 1'b1;
          last_sign_q[i] <= tick_sign[i];
        end else begin
          if (stall_fire[i]) begin
            armed_q[i] <= 1'b0;
          end
          if (us_tick && (cnt_q[i] != CNT_MAX)) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_stall;

  // Without the stall monitor only real ticks produce samples
  assign stall_fire   = '0;
  assign stall_sign   = '0;
  assign unused_stall = us_tick ^ (TIMEOUT_US > 0);
`endif

  // Round-robin pick: the first pending channel after last_grant wins
  always_comb begin
    logic [CH_W:0] idx;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = {1'b0, last_grant_q} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH)) begin
        idx = idx - (CH_W+1)'(NUM_CH);
      end
      if (pend_q[idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = idx[CH_W-1:0];
      end
    end
  end

  assign out_free = !out_valid_q || out_ready;
  assign take     = out_free && grant_vld;

  // Buffer update, overrun tracking and output register next-state
  always_comb begin
    logic [NUM_CH-1:0] ovr_set;
    logic              new_vld;
    logic              granted;
    pend_d       = pend_q;
    psgn_d       = psgn_q;
    ovr_set      = '0;
    new_vld      = 1'b0;
    granted      = 1'b0;
    out_valid_d  = out_valid_q;
    out_period_d = out_period_q;
    out_sign_d   = out_sign_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pper_d[i] = pper_q[i];
      new_vld   = tick_valid[i] || stall_fire[i];
      granted   = take && (grant_ch == CH_W'(i));
      if (new_vld) begin
        pend_d[i] = 1'b1;
        pper_d[i] = tick_valid[i] ? tick_period[32*i +: 32] : MAX_PERIOD;
        psgn_d[i] = tick_valid[i] ? tick_sign[i] : stall_sign[i];
        if (pend_q[i] && !granted) begin
          ovr_set[i] = 1'b1;
        end
      end else if (granted) begin
        pend_d[i] = 1'b0;
      end
    end
    if (out_free) begin
      if (grant_vld) begin
        out_valid_d  = 1'b1;
        out_period_d = pper_q[grant_ch];
        out_sign_d   = psgn_q[grant_ch];
        out_ch_d     = grant_ch;
        last_grant_d = grant_ch;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // A new overrun in the same cycle as a clear stays set
    overrun_d = (clear_overrun ? '0 : overrun_q) | ovr_set;
  end

  // State registers; reset drops any buffered or in-flight sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q       <= '0;
      psgn_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pper_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_period_q <= '0;
      out_sign_q   <= 1'b0;
      out_ch_q     <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      overrun_q    <= '0;
    end else begin
      pend_q       <= pend_d;
      psgn_q       <= psgn_d;
      for (int i = 0; i < NUM_CH; i++) begin
        pper_q[i] <= pper_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_period_q <= out_period_d;
      out_sign_q   <= out_sign_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_period = out_period_q;
  assign out_sign   = out_sign_q;
  assign out_ch     = out_ch_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_tick_sample_arbiter.sv
// Testbench for tick_sample_arbiter (NUM_CH=2, TIMEOUT_US=4).
// Stall-sample expectations are only queued when TICK_STALL_TIMEOUT_EN is
// defined. Without it, the same us_tick stimulus must produce no output.
module tb_tick_sample_arbiter;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int EW     = CH_W + 33;

  logic                 clk;
  logic                 reset;
  logic                 us_tick;
  logic [NUM_CH-1:0]    tick_valid;
  logic [32*NUM_CH-1:0] tick_period;
  logic [NUM_CH-1:0]    tick_sign;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_period;
  logic                 out_sign;
  logic [CH_W-1:0]      out_ch;
  logic [NUM_CH-1:0]    overrun;
  logic                 clear_overrun;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;

  tick_sample_arbiter #(
    .NUM_CH     (NUM_CH),
    .TIMEOUT_US (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .us_tick       (us_tick),
    .tick_valid    (tick_valid),
    .tick_period   (tick_period),
    .tick_sign     (tick_sign),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_period    (out_period),
    .out_sign      (out_sign),
    .out_ch        (out_ch),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 2 time units after the rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_tick(input int ch, input logic [31:0] per, input logic sgn);
    tick_valid[ch]          = 1'b1;
    tick_period[32*ch +: 32] = per;
    tick_sign[ch]           = sgn;
  endtask

  task automatic push_exp(input logic [CH_W-1:0] ch, input logic sgn,
                          input logic [31:0] per);
    exp_q.push_back({ch, sgn, per});
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic us_strobes(input int n);
    for (int s = 0; s < n; s++) begin
      us_tick = 1'b1;
      step(1);
      us_tick = 1'b0;
      step(1);
    end
  endtask

  // Scoreboard monitor: every accepted output sample is popped and compared
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got ch=%0d sign=%0d period=%0h, none expected",
                 out_ch, out_sign, out_period);
      end else begin
        exp_v = exp_q.pop_front();
        if ({out_ch, out_sign, out_period} !== exp_v) begin
          errors++;
          $display("FAIL sample: got ch=%0d sign=%0d period=%0h expected ch=%0d sign=%0d period=%0h",
                   out_ch, out_sign, out_period,
                   exp_v[EW-1 -: CH_W], exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    us_tick       = 1'b0;
    tick_valid    = '0;
    tick_period   = '0;
    tick_sign     = '0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    step(2);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_period", 64'(out_period), 64'd0);
    check("reset_out_sign", 64'(out_sign), 64'd0);
    check("reset_out_ch", 64'(out_ch), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    reset = 1'b0;
    step(1);

    // Single sample with latency checks
    out_ready = 1'b1;
    set_tick(1, 32'd1234, 1'b1);
    push_exp(1'b1, 1'b1, 32'd1234);
    step(1);
    tick_valid = '0;
    check("latency_not_yet", 64'(out_valid), 64'd0);
    step(1);
    check("latency_valid", 64'(out_valid), 64'd1);
    step(1);
    check("single_then_idle", 64'(out_valid), 64'd0);

    // Round robin: last_grant=1 so ch0 first
    set_tick(0, 32'd100, 1'b0);
    set_tick(1, 32'd200, 1'b0);
    push_exp(1'b0, 1'b0, 32'd100);
    push_exp(1'b1, 1'b0, 32'd200);
    step(1);
    tick_valid = '0;
    step(4);
    // Make last_grant=0, then both again: ch1 first
    set_tick(0, 32'd50, 1'b1);
    push_exp(1'b0, 1'b1, 32'd50);
    step(1);
    tick_valid = '0;
    step(3);
    set_tick(0, 32'd300, 1'b0);
    set_tick(1, 32'd400, 1'b1);
    push_exp(1'b1, 1'b1, 32'd400);
    push_exp(1'b0, 1'b0, 32'd300);
    step(1);
    tick_valid = '0;
    step(4);

    // Backpressure: output holds ch0/100 while ch1/200 waits
    out_ready = 1'b0;
    set_tick(0, 32'd100, 1'b0);
    push_exp(1'b0, 1'b0, 32'd100);
    step(1);
    tick_valid = '0;
    step(1);
    set_tick(1, 32'd200, 1'b1);
    push_exp(1'b1, 1'b1, 32'd200);
    step(1);
    tick_valid = '0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("hold_word", {out_valid, out_ch, out_period}, {1'b1, 1'b0, 32'd100});
    end
    out_ready = 1'b1;
    step(4);

    // Overrun: ch1 sends 5 then 6 while the output is blocked
    out_ready = 1'b0;
    set_tick(0, 32'd7, 1'b0);
    push_exp(1'b0, 1'b0, 32'd7);
    step(1);
    tick_valid = '0;
    step(2);
    set_tick(1, 32'd5, 1'b0);
    step(1);
    set_tick(1, 32'd6, 1'b1);
    push_exp(1'b1, 1'b1, 32'd6);
    step(1);
    tick_valid = '0;
    check("overrun_set", 64'(overrun), 64'd2);
    out_ready = 1'b1;
    step(4);
    check("overrun_sticky", 64'(overrun), 64'd2);
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
    check("overrun_cleared", 64'(overrun), 64'd0);

    // Stall monitor: both channels tick, then go quiet
    set_tick(0, 32'd77, 1'b0);
    set_tick(1, 32'd88, 1'b1);
    push_exp(1'b0, 1'b0, 32'd77);
    push_exp(1'b1, 1'b1, 32'd88);
    step(1);
    tick_valid = '0;
    step(3);
`ifdef TICK_STALL_TIMEOUT_EN
    push_exp(1'b0, 1'b0, 32'hFFFFFFFF);
    push_exp(1'b1, 1'b1, 32'hFFFFFFFF);
`endif
    us_strobes(4);
    step(4);
    us_strobes(6);
    step(2);
    // Re-arm ch0 with a new tick, then stall it again
    set_tick(0, 32'd9, 1'b1);
    push_exp(1'b0, 1'b1, 32'd9);
    step(1);
    tick_valid = '0;
    step(3);
`ifdef TICK_STALL_TIMEOUT_EN
    push_exp(1'b0, 1'b1, 32'hFFFFFFFF);
`endif
    us_strobes(4);
    step(4);
    check("queue_drained_pre_reset", 64'(exp_q.size()), 64'd0);

    // Async reset mid-operation: in-flight and pending samples are dropped
    out_ready = 1'b0;
    set_tick(0, 32'd11, 1'b0);
    set_tick(1, 32'd22, 1'b1);
    step(1);
    tick_valid = '0;
    step(1);
    set_tick(1, 32'd33, 1'b0);
    step(1);
    tick_valid = '0;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_word", {out_valid, out_ch, out_sign, out_period},
          {1'b0, 1'b0, 1'b0, 32'd0});
    check("async_reset_overrun", 64'(overrun), 64'd0);
    step(1);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1);
      check("post_reset_idle", 64'(out_valid), 64'd0);
    end
    set_tick(1, 32'd55, 1'b0);
    push_exp(1'b1, 1'b0, 32'd55);
    step(1);
    tick_valid = '0;
    step(4);
    check("queue_drained_end", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
